// File: rtl/alu_pkg.sv
// Opcode constants shared by the external ALU and every block that drives it.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_ASL  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1101;
  localparam logic [3:0] ALU_EOR  = 4'b1110;
  localparam logic [3:0] ALU_PASS = 4'b1111;
endpackage

// File: rtl/mul8_seq_if.sv
// Operand/result handshake bundle of the sequential 8x8 multiplier.
interface mul8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P
  );
endinterface

// File: rtl/mul8_seq.sv
// Shift-add 8x8 unsigned multiplier that borrows an external 8-bit ALU for
// every add and right shift; each of the 8 iterations spends 6 states.
module mul8_seq
  import alu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RDY,
  mul8_seq_if.slave  bus,
  output logic [3:0] alu_op,
  output logic       alu_right,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_CI,
  output logic       alu_BCD,
  output logic       alu_RDY,
  input  logic [7:0] alu_OUT,
  input  logic       alu_CO
);

  typedef enum logic [2:0] {
    IDLE, ADD_I, ADD_W, SHH_I, SHH_W, SHL_I, SHL_W, DONE
  } state_t;

  state_t     state;
  logic [7:0] M, H, L;
  logic       c;
  logic [2:0] iter;
  logic       issue;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      M     <= '0;
      H     <= '0;
      L     <= '0;
      c     <= 1'b0;
      iter  <= '0;
    end else if (RDY) begin
      case (state)
        IDLE: if (bus.in_valid) begin
          M     <= bus.A;
          L     <= bus.B;
          H     <= '0;
          c     <= 1'b0;
          iter  <= '0;
          state <= ADD_I;
        end
        ADD_I: state <= ADD_W;
        ADD_W: begin
          H     <= alu_OUT;
          c     <= alu_CO;
          state <= SHH_I;
        end
        SHH_I: state <= SHH_W;
        // c now carries the bit shifted out of H into the top of L
        SHH_W: begin
          H     <= alu_OUT;
          c     <= alu_CO;
          state <= SHL_I;
        end
        SHL_I: state <= SHL_W;
        SHL_W: begin
          L     <= alu_OUT;
          iter  <= iter + 3'd1;
          state <= (iter == 3'd7) ? DONE : ADD_I;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign issue = (state == ADD_I) || (state == SHH_I) || (state == SHL_I);

  // The ALU only latches in issue states, so it holds OUT through the wait states.
  always_comb begin
    alu_op    = '0;
    alu_right = 1'b0;
    alu_AI    = '0;
    alu_BI    = '0;
    alu_CI    = 1'b0;
    case (state)
      ADD_I: begin
        alu_op = ALU_ADD;
        alu_AI = H;
        alu_BI = L[0] ? M : 8'd0;
      end
      SHH_I: begin
        alu_op    = ALU_PASS;
        alu_right = 1'b1;
        alu_AI    = H;
        alu_CI    = c;
      end
      SHL_I: begin
        alu_op    = ALU_PASS;
        alu_right = 1'b1;
        alu_AI    = L;
        alu_CI    = c;
      end
      default: ;
    endcase
  end

  assign alu_BCD       = 1'b0;
  assign alu_RDY       = RDY & issue;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.P         = (state == DONE) ? {H, L} : 16'd0;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed bench for mul8_seq with a behavioural model of the external ALU.
module tb_mul8_seq;
  import alu_pkg::*;

  logic       CLK;
  logic       RST;
  logic       RDY;
  logic [3:0] alu_op;
  logic       alu_right;
  logic [7:0] alu_AI;
  logic [7:0] alu_BI;
  logic       alu_CI;
  logic       alu_BCD;
  logic       alu_RDY;
  logic [7:0] alu_OUT;
  logic       alu_CO;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  mul8_seq_if bus ();

  mul8_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .RDY       (RDY),
    .bus       (bus.slave),
    .alu_op    (alu_op),
    .alu_right (alu_right),
    .alu_AI    (alu_AI),
    .alu_BI    (alu_BI),
    .alu_CI    (alu_CI),
    .alu_BCD   (alu_BCD),
    .alu_RDY   (alu_RDY),
    .alu_OUT   (alu_OUT),
    .alu_CO    (alu_CO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU: add with carry, or rotate-right through carry.
  initial begin
    alu_OUT = 8'd0;
    alu_CO  = 1'b0;
  end
  always @(posedge CLK) begin
    if (alu_RDY) begin
      if (alu_right)
        {alu_OUT, alu_CO} <= {alu_CI, alu_AI};
      else if (alu_op == ALU_ADD)
        {alu_CO, alu_OUT} <= {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_CI};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_done(input int start_e, input int stall_at, input int stall_len,
                           output int l);
    l = -1;
    for (int e = start_e; e <= 120 && l < 0; e++) begin
      if (e == stall_at) RDY = 1'b0;
      if (e == stall_at + stall_len) RDY = 1'b1;
      @(posedge CLK); #1;
      if (!RDY) check("stall_alu_rdy", 32'(alu_RDY), 32'd0);
      if (bus.out_valid) l = e;
    end
    RDY = 1'b1;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    check("hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("hs_P_zero", 32'(bus.P), 32'd0);
    check("hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    RST = 1'b1;
    RDY = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = 8'd0;
    bus.B = 8'd0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_P", 32'(bus.P), 32'd0);
    check("rst_alu_rdy", 32'(alu_RDY), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_bcd", 32'(alu_BCD), 32'd0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;

    // 13 * 11, including the first ADD_I and ADD_W drives
    accept(8'd13, 8'd11);
    check("addi_op", 32'(alu_op), 32'(ALU_ADD));
    check("addi_right", 32'(alu_right), 32'd0);
    check("addi_AI", 32'(alu_AI), 32'd0);
    check("addi_BI", 32'(alu_BI), 32'd13);
    check("addi_CI", 32'(alu_CI), 32'd0);
    check("addi_alu_rdy", 32'(alu_RDY), 32'd1);
    @(posedge CLK); #1;
    check("addw_alu_rdy", 32'(alu_RDY), 32'd0);
    check("addw_op", 32'(alu_op), 32'd0);
    check("addw_AI", 32'(alu_AI), 32'd0);
    check("addw_P", 32'(bus.P), 32'd0);
    @(posedge CLK); #1;
    check("shhi_op", 32'(alu_op), 32'(ALU_PASS));
    check("shhi_right", 32'(alu_right), 32'd1);
    check("shhi_AI", 32'(alu_AI), 32'd13);
    wait_done(3, -1, 0, lat);
    check("lat_13x11", 32'(lat), 32'd48);
    check("P_13x11", 32'(bus.P), 32'h008F);
    handshake();

    accept(8'hFF, 8'hFF);
    wait_done(1, -1, 0, lat);
    check("lat_FFxFF", 32'(lat), 32'd48);
    check("P_FFxFF", 32'(bus.P), 32'hFE01);
    handshake();

    accept(8'h00, 8'hAB);
    wait_done(1, -1, 0, lat);
    check("lat_00xAB", 32'(lat), 32'd48);
    check("P_00xAB", 32'(bus.P), 32'h0000);
    handshake();

    // RDY low for edges 20..24 stretches the latency by 5
    accept(8'h80, 8'h02);
    wait_done(1, 20, 5, lat);
    check("lat_stall", 32'(lat), 32'd53);
    check("P_stall", 32'(bus.P), 32'h0100);
    handshake();

    // Asynchronous reset in the middle of an operation
    accept(8'h55, 8'h33);
    repeat (20) begin
      @(posedge CLK); #1;
    end
    check("mid_in_ready", 32'(bus.in_ready), 32'd0);
    RST = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_alu_rdy", 32'(alu_RDY), 32'd0);
    check("arst_P", 32'(bus.P), 32'd0);
    #1;
    RST = 1'b0;
    accept(8'd7, 8'd9);
    wait_done(1, -1, 0, lat);
    check("lat_7x9", 32'(lat), 32'd48);
    check("P_7x9", 32'(bus.P), 32'h003F);

    // Result held under back-pressure while a new operand waits
    bus.A = 8'h12;
    bus.B = 8'h34;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(posedge CLK); #1;
      check("hold_P", 32'(bus.P), 32'h003F);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    check("next_accept_in_ready", 32'(bus.in_ready), 32'd0);
    check("next_accept_op", 32'(alu_op), 32'(ALU_ADD));
    wait_done(1, -1, 0, lat);
    check("lat_12x34", 32'(lat), 32'd48);
    check("P_12x34", 32'(bus.P), 32'h03A8);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul8_seq.md
MUL8_SEQ -- requirements
Module: mul8_seq

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port RDY, input, 1 bit: global stall; low freezes the block and the ALU.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), A (input, 8, multiplicand) and B (input, 8, multiplier).
REQ-005 SHALL have ports out_valid (output, 1), out_ready (input, 1) and P (output, 16, unsigned product).
REQ-006 SHALL have ALU drive ports, all outputs: alu_op (4), alu_right (1), alu_AI (8), alu_BI (8), alu_CI (1), alu_BCD (1), alu_RDY (1).
REQ-007 SHALL have ALU return ports, both inputs: alu_OUT (8) and alu_CO (1).

Function
REQ-008 SHALL compute P = A*B unsigned using only the external ALU for add and shift; the block contains no adder wider than the 3-bit iteration counter.
REQ-009 SHALL hold internal registers M (8), H (8), L (8), c (1) and iter (3).
REQ-010 SHALL use FSM states IDLE, ADD_I, ADD_W, SHH_I, SHH_W, SHL_I, SHL_W, DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; an accept occurs when in_valid & in_ready & RDY.
REQ-012 SHALL, on accept, load M=A, L=B, H=0, c=0, iter=0 and go to ADD_I.
REQ-013 SHALL, in ADD_I, drive alu_op=0011, alu_right=0, alu_AI=H, alu_BI=(L[0] ? M : 0), alu_CI=0.
REQ-014 SHALL, in ADD_W, capture H=alu_OUT and c=alu_CO.
REQ-015 SHALL, in SHH_I, drive alu_op=1111, alu_right=1, alu_AI=H, alu_CI=c.
REQ-016 SHALL, in SHH_W, capture H=alu_OUT and c=alu_CO (the old H[0]).
REQ-017 SHALL, in SHL_I, drive alu_op=1111, alu_right=1, alu_AI=L, alu_CI=c.
REQ-018 SHALL, in SHL_W, capture L=alu_OUT, increment iter, and go to ADD_I if iter was less than 7, else to DONE.
REQ-019 SHALL drive alu_BCD=0 always.
REQ-020 SHALL drive alu_RDY = RDY & (state is ADD_I, SHH_I or SHL_I), so the ALU holds OUT during *_W states.
REQ-021 SHALL drive all ALU inputs to 0 outside the *_I states.
REQ-022 SHALL advance every state transition only on edges where RDY=1; with RDY=0 all registers hold.
REQ-023 SHALL present out_valid=1 and P={H,L} in DONE.
REQ-024 SHALL return from DONE to IDLE on out_valid & out_ready & RDY.
REQ-025 SHALL hold P stable while out_valid=1 and drive P=0 outside DONE.
REQ-026 SHALL, with RDY held high, assert out_valid exactly 48 rising edges after the accepting edge (8 iterations x 6 states).
REQ-027 SHALL ignore in_valid outside IDLE, including in DONE; no new accept may occur in the same cycle as out acceptance.
REQ-028 SHALL produce the same fixed latency for every operand value, zero included.

Reset
REQ-029 SHALL, on RST high (asynchronously, even mid-operation), set state to IDLE and clear M, H, L, c and iter to 0.
REQ-030 SHALL, while RST is high, drive in_ready=1, out_valid=0, P=0, alu_RDY=0 and all other ALU drives to 0.
REQ-031 SHALL accept a new operand pair on the first RDY-high edge after RST deasserts.

Structure
REQ-032 SHALL take ALU opcode constants (ADD 0011, SUB 0111, ASL 1011, OR 1100, AND 1101, EOR 1110, PASS 1111) from shared package alu_pkg.
REQ-033 SHALL keep the FSM state encoding local to mul8_seq.
REQ-034 SHALL contain no sub-module; the ALU is instantiated beside mul8_seq in the parent, port-to-port.

Verification
REQ-035 SHALL cover: A=13, B=11, RDY=1 -> P=0x008F, out_valid on edge 48 after accept.
REQ-036 SHALL cover: A=0xFF, B=0xFF -> P=0xFE01; and A=0x00, B=0xAB -> P=0x0000 with the same 48-edge latency.
REQ-037 SHALL cover: A=0x80, B=0x02 with RDY low for 5 cycles at edge 20 -> P=0x0100, out_valid on edge 53, alu_RDY=0 throughout the stall.
REQ-038 SHALL cover: RST pulse at edge 20 of A=0x55, B=0x33 -> out_valid=0 and in_ready=1 immediately; next op A=7, B=9 -> P=0x003F.
REQ-039 SHALL cover: out_ready low for 10 cycles in DONE with in_valid high -> P held constant, no accept until one cycle after out handshake.
